// File: rtl/video_capture.sv
// video_capture: arms on request, captures one VS-delimited frame into a FWFT FIFO with running CRC-32 and line stats.
module video_capture #(
    parameter int PIX_W   = 24,
    parameter int FIFO_AW = 8,
    parameter int CNT_W   = 12
) (
    input  logic               CLK,
    input  logic               RESB,
    input  logic               CE,
    input  logic               DE,
    input  logic               VS,
    input  logic [PIX_W-1:0]   PIX,
    input  logic               ARM,
    input  logic               ABORT,
    input  logic               MODE,
    input  logic               RD,
    output logic [PIX_W+1:0]   DOUT,
    output logic               EMPTY,
    output logic               FULL,
    output logic               OVF,
    output logic               BUSY,
    output logic               DONE,
    output logic [CNT_W-1:0]   LINES,
    output logic [CNT_W-1:0]   LAST_W,
    output logic [31:0]        CRC
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAP, S_DONE} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t state_q, state_d;
    logic vs_prev_q, de_prev_q, mode_q, sof_q, in_line_q, ovf_q, busy_q, done_q;
    logic [CNT_W-1:0] lines_q, last_w_q, pix_cnt_q;
    logic [31:0] crc_q, crc_d;
    logic [FIFO_AW:0] wr_q, rd_q;
    logic [PIX_W+1:0] mem [2**FIFO_AW];
    logic vs_edge, arm_ok, cap_pix, sol, line_end, push, pop;
    assign vs_edge  = CE && VS && !vs_prev_q;
    assign arm_ok   = ARM && !ABORT && (state_q == S_IDLE || state_q == S_DONE);
    assign cap_pix  = CE && DE && !ABORT && state_q == S_CAP;
    assign sol      = cap_pix && !de_prev_q;
    assign line_end = CE && !DE && !ABORT && in_line_q && state_q == S_CAP;
    // a full FIFO still accepts a push when the head is popped on the same edge
    assign push     = cap_pix && !mode_q && (!FULL || RD);
    assign pop      = RD && !EMPTY && !ABORT;
    assign EMPTY    = wr_q == rd_q;
    assign FULL     = (wr_q ^ rd_q) == {1'b1, {FIFO_AW{1'b0}}};
    assign DOUT     = mem[rd_q[FIFO_AW-1:0]];
    assign OVF      = ovf_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign LINES    = lines_q;
    assign LAST_W   = last_w_q;
    assign CRC      = crc_q;
    always_comb begin
        state_d = ABORT ? S_IDLE : arm_ok ? S_WAIT : !vs_edge ? state_q :
                  state_q == S_WAIT ? S_CAP : state_q == S_CAP ? S_DONE : state_q;
    end
    always_comb begin
        crc_d = crc_q;
        for (int i = PIX_W - 1; i >= 0; i--)
            crc_d = {crc_d[30:0], 1'b0} ^ ((crc_d[31] ^ PIX[i]) ? 32'h04C11DB7 : 32'h0);
    end
    always_ff @(posedge CLK) begin
        if (push) mem[wr_q[FIFO_AW-1:0]] <= {sof_q, sol, PIX};
    end
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            vs_prev_q <= 1'b1;
            de_prev_q <= 1'b0;
            mode_q    <= 1'b0;
            sof_q     <= 1'b0;
            in_line_q <= 1'b0;
            ovf_q     <= 1'b0;
            lines_q   <= '0;
            last_w_q  <= '0;
            pix_cnt_q <= '0;
            crc_q     <= 32'hFFFFFFFF;
            wr_q      <= '0;
            rd_q      <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= state_d == S_WAIT || state_d == S_CAP;
            done_q  <= state_d == S_DONE;
            if (CE) begin
                vs_prev_q <= VS;
                de_prev_q <= DE;
            end
            if (ABORT) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (push) wr_q <= wr_q + 1'b1;
                if (pop) rd_q <= rd_q + 1'b1;
            end
            if (arm_ok) begin
                lines_q   <= '0;
                last_w_q  <= '0;
                ovf_q     <= 1'b0;
                crc_q     <= 32'hFFFFFFFF;
                mode_q    <= MODE;
                sof_q     <= 1'b1;
                in_line_q <= 1'b0;
            end else begin
                if (cap_pix) begin
                    crc_q     <= crc_d;
                    sof_q     <= 1'b0;
                    in_line_q <= 1'b1;
                    pix_cnt_q <= sol ? CNT_W'(1) : pix_cnt_q + CNT_W'(pix_cnt_q != CNT_MAX);
                end
                if (sol && lines_q != CNT_MAX) lines_q <= lines_q + 1'b1;
                if (line_end) begin
                    last_w_q  <= pix_cnt_q;
                    in_line_q <= 1'b0;
                end
                if (cap_pix && !mode_q && FULL && !RD) ovf_q <= 1'b1;
            end
        end
    end
endmodule
